// File: rtl/jtkunio_sndcmd_pkg.sv
// Shared types for the sound command channel: per-side handshake states and
// the width of the queue occupancy count.
package jtkunio_sndcmd_pkg;

  localparam int CW = 5;

  typedef enum logic {
    WIDLE = 1'b0,
    WHELD = 1'b1
  } wst_t;

  typedef enum logic {
    RIDLE = 1'b0,
    RACT  = 1'b1
  } rdst_t;

endpackage

// File: rtl/jtkunio_sndcmd_fifo.sv
// DEPTH x 8 register FIFO. Occupancy comes from cnt, never from pointer
// equality, so full and empty stay unambiguous when the pointers wrap.
module jtkunio_sndcmd_fifo
  import jtkunio_sndcmd_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nx,
  output logic          full
);

  logic [7:0]    mem [0:(2**AW)-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a push while full is accepted then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign head   = mem[rd_ptr_q];
  assign cnt    = cnt_q;
  assign cnt_nx = cnt_d;

endmodule

// File: rtl/jtkunio_sndcmd.sv
// Sound-side command latch/queue: one push per main-CPU strobe, one pop per
// sound-CPU read (issued as the read ends), IRQ while anything is queued.
module jtkunio_sndcmd
  import jtkunio_sndcmd_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_we,
  input  logic [7:0] main_dout,
  input  logic       snd_cs,
  input  logic       snd_rnw,
  output logic [7:0] dout,
  output logic       irq,
  output logic       irqn,
  output logic [4:0] cnt,
  output logic       ovf
);

  wst_t          wst_q, wst_d;
  rdst_t         rdst_q, rdst_d;
  logic          rd_q;
  logic [7:0]    dout_q, dout_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, fifo_pop;
  logic [7:0]    head;
  logic [CW-1:0] fifo_cnt, fifo_cnt_nx;
  logic          full;

  // Write side resets to WHELD so a strobe still high out of reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst_q  <= WHELD;
      rdst_q <= RIDLE;
      rd_q   <= 1'b0;
      dout_q <= '0;
      irq_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wst_q  <= wst_d;
      rdst_q <= rdst_d;
      rd_q   <= snd_cs & snd_rnw;
      dout_q <= dout_d;
      irq_q  <= irq_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      WIDLE:   if (main_we)  wst_d = WHELD;
      WHELD:   if (!main_we) wst_d = WIDLE;
      default: wst_d = WHELD;
    endcase
    rdst_d = rdst_q;
    case (rdst_q)
      RIDLE:   if (rd_q)  rdst_d = RACT;
      RACT:    if (!rd_q) rdst_d = RIDLE;
      default: rdst_d = RIDLE;
    endcase
  end

  always_comb begin
    push = (wst_q == WIDLE) && main_we;
    pop  = (rdst_q == RACT) && !rd_q;
  end

  // Single-latch mode: a push into a full latch is a replace, i.e. pop+push.
  assign fifo_pop = pop | ((DEPTH == 1) && push && full);

  jtkunio_sndcmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (fifo_pop),
    .din    (main_dout),
    .head   (head),
    .cnt    (fifo_cnt),
    .cnt_nx (fifo_cnt_nx),
    .full   (full)
  );

  always_comb begin
    ovf_d  = ovf_q | (push & full & ~pop);
    irq_d  = (fifo_cnt_nx != '0);
    dout_d = (fifo_cnt != '0) ? head : dout_q;
  end

  assign dout = dout_q;
  assign irq  = irq_q;
  assign irqn = ~irq_q;
  assign cnt  = fifo_cnt;
  assign ovf  = ovf_q;

endmodule
